// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer
//   Captures per-cycle CPU retire information (PC, register-file write,
//   data-memory write) into a first-word-fall-through FIFO, tagging each
//   record with a running cycle count. Capture can be limited to cycles
//   that write state (MODE=1). When the FIFO is full, a new record is
//   either dropped and counted (STOP_ON_FULL=0), or capture freezes
//   (STOP_ON_FULL=1).
//
// Ports
//   clk, reset           clock (rising edge), async active-high reset
//   en, clr              trace enable, synchronous clear
//   pc                   PC of the instruction retiring this cycle
//   reg_we/waddr/wdata   register-file write port
//   mem_we/addr/wdata    data-memory write port
//   rd_valid/ready/data  FWFT read side; rd_data =
//                        {cyc, pc, rflag, mflag, reg_waddr, reg_wdata,
//                         mem_addr, mem_wdata}
//   count                occupied entries
//   overflow, drops      sticky drop flag, saturating drop counter
//   frozen               capture halted because the FIFO filled
//   cycle                running cycle count
//
// States
//   IDLE   | not tracing; waits for en
//   RUN    | tracing; cycle counts, capture events push records
//   FROZEN | FIFO filled with STOP_ON_FULL=1; capture halted until clr
module cpu_trace_buffer #(
  parameter int DEPTH        = 16,
  parameter int CYC_W        = 32,
  parameter int MODE         = 0,
  parameter int STOP_ON_FULL = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   clr,
  input  logic [31:0]            pc,
  input  logic                   reg_we,
  input  logic [4:0]             reg_waddr,
  input  logic [31:0]            reg_wdata,
  input  logic                   mem_we,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [CYC_W+134:0]     rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [15:0]            drops,
  output logic                   frozen,
  output logic [CYC_W-1:0]       cycle
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = CYC_W + 135;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic [RW-1:0]   record;
  logic            rflag;
  logic            mflag;
  logic            running;
  logic            capture;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // A write to $zero is architecturally a no-op, so it is not a register write.
  assign rflag   = reg_we && (reg_waddr != 5'd0);
  assign mflag   = mem_we;
  assign running = en && (state == RUN);

  // clr wins over any push on the same edge.
  assign capture = running && !clr && ((MODE == 0) || rflag || mflag);
  assign full    = (count == DEPTH_C);
  assign rd_valid = (count != '0);
  assign pop     = rd_valid && rd_ready;
  // A full FIFO still accepts a record when the head leaves on the same edge.
  assign push    = capture && (!full || pop);
  assign drop    = capture && !push && (STOP_ON_FULL == 0);

  assign count_next = count + CW'(push) - CW'(pop);
  assign record = {cycle, pc, rflag, mflag, reg_waddr, reg_wdata, mem_addr, mem_wdata};

  // Gate the head with rd_valid so an empty FIFO always presents zeros.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;
  assign frozen  = (state == FROZEN);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN: begin
        if ((STOP_ON_FULL != 0) && push && (count_next == DEPTH_C))
          state_next = FROZEN;
        else if (!en)
          state_next = IDLE;
      end
      FROZEN:  state_next = FROZEN;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drops    <= '0;
      cycle    <= '0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drops    <= '0;
      cycle    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      if (drop) begin
        overflow <= 1'b1;
        if (drops != 16'hFFFF) drops <= drops + 16'd1;
      end
      if (running) cycle <= cycle + CYC_W'(1);
    end
  end

  // Storage carries no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= record;
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
module tb_cpu_trace_buffer;

  localparam int RW = 167;
  localparam int P_DEPTH [3] = '{16, 4, 4};
  localparam int P_MODE  [3] = '{0, 1, 0};
  localparam int P_SOF   [3] = '{0, 0, 1};

  logic        clk;
  logic        reset;
  logic        en;
  logic        clr;
  logic [31:0] pc;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        rd_ready;

  logic          rv_a, rv_b, rv_c;
  logic [RW-1:0] rd_a, rd_b, rd_c;
  logic [4:0]    cnt_a;
  logic [2:0]    cnt_b, cnt_c;
  logic          ovf_a, ovf_b, ovf_c;
  logic [15:0]   drops_a, drops_b, drops_c;
  logic          frz_a, frz_b, frz_c;
  logic [31:0]   cyc_a, cyc_b, cyc_c;

  int errors;
  int checks;

  // behavioural model: one queue of records per instance
  logic [RW-1:0] mq [3][$];
  logic [31:0]   mcyc   [3];
  logic [15:0]   mdrops [3];
  logic          movf   [3];
  int            mst    [3];   // 0 idle, 1 run, 2 frozen

  cpu_trace_buffer #(.DEPTH(16), .CYC_W(32), .MODE(0), .STOP_ON_FULL(0)) u_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .pc(pc),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_valid(rv_a), .rd_ready(rd_ready), .rd_data(rd_a), .count(cnt_a),
    .overflow(ovf_a), .drops(drops_a), .frozen(frz_a), .cycle(cyc_a));

  cpu_trace_buffer #(.DEPTH(4), .CYC_W(32), .MODE(1), .STOP_ON_FULL(0)) u_b (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .pc(pc),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_valid(rv_b), .rd_ready(rd_ready), .rd_data(rd_b), .count(cnt_b),
    .overflow(ovf_b), .drops(drops_b), .frozen(frz_b), .cycle(cyc_b));

  cpu_trace_buffer #(.DEPTH(4), .CYC_W(32), .MODE(0), .STOP_ON_FULL(1)) u_c (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .pc(pc),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .rd_valid(rv_c), .rd_ready(rd_ready), .rd_data(rd_c), .count(cnt_c),
    .overflow(ovf_c), .drops(drops_c), .frozen(frz_c), .cycle(cyc_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_rec(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      mcyc[i]   = '0;
      mdrops[i] = '0;
      movf[i]   = 1'b0;
      mst[i]    = 0;
    end
  endtask

  task automatic model_step();
    logic rf, pp, cap, acc;
    if (reset) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (clr) begin
        mq[i].delete();
        mcyc[i]   = '0;
        mdrops[i] = '0;
        movf[i]   = 1'b0;
        mst[i]    = 0;
      end else begin
        rf  = reg_we && (reg_waddr != 5'd0);
        pp  = (mq[i].size() > 0) && rd_ready;
        cap = en && (mst[i] == 1) && ((P_MODE[i] == 0) || rf || mem_we);
        acc = cap && ((mq[i].size() < P_DEPTH[i]) || pp);
        if (pp) void'(mq[i].pop_front());
        if (acc) mq[i].push_back({mcyc[i], pc, rf, mem_we, reg_waddr, reg_wdata, mem_addr, mem_wdata});
        if (cap && !acc && (P_SOF[i] == 0)) begin
          movf[i] = 1'b1;
          if (mdrops[i] != 16'hFFFF) mdrops[i] = mdrops[i] + 16'd1;
        end
        if (en && (mst[i] == 1)) mcyc[i] = mcyc[i] + 32'd1;
        if (mst[i] == 0) begin
          if (en) mst[i] = 1;
        end else if (mst[i] == 1) begin
          if ((P_SOF[i] != 0) && acc && (mq[i].size() == P_DEPTH[i])) mst[i] = 2;
          else if (!en) mst[i] = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [RW-1:0] d, exp_d;
    logic          v, o, f;
    logic [15:0]   dr;
    logic [31:0]   cy;
    int            c;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       begin d = rd_a; v = rv_a; c = int'(cnt_a); o = ovf_a; dr = drops_a; f = frz_a; cy = cyc_a; end
        1:       begin d = rd_b; v = rv_b; c = int'(cnt_b); o = ovf_b; dr = drops_b; f = frz_b; cy = cyc_b; end
        default: begin d = rd_c; v = rv_c; c = int'(cnt_c); o = ovf_c; dr = drops_c; f = frz_c; cy = cyc_c; end
      endcase
      exp_d = (mq[i].size() > 0) ? mq[i][0] : '0;
      chk_rec($sformatf("u%0d.rd_data", i), d, exp_d);
      chk($sformatf("u%0d.rd_valid", i), 64'(v), 64'(mq[i].size() > 0));
      chk($sformatf("u%0d.count", i), 64'(c), 64'(mq[i].size()));
      chk($sformatf("u%0d.overflow", i), 64'(o), 64'(movf[i]));
      chk($sformatf("u%0d.drops", i), 64'(dr), 64'(mdrops[i]));
      chk($sformatf("u%0d.frozen", i), 64'(f), 64'(mst[i] == 2));
      chk($sformatf("u%0d.cycle", i), 64'(cy), 64'(mcyc[i]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_in();
    en = 0; clr = 0; rd_ready = 0; pc = '0;
    reg_we = 0; reg_waddr = '0; reg_wdata = '0;
    mem_we = 0; mem_addr = '0; mem_wdata = '0;
  endtask

  logic [31:0] exp5 [4];

  initial begin
    errors = 0;
    checks = 0;
    idle_in();
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_count_a", 64'(cnt_a), 64'd0);
    chk("rst_valid_a", 64'(rv_a), 64'd0);
    chk_rec("rst_data_a", rd_a, '0);
    chk("rst_cycle_c", 64'(cyc_c), 64'd0);
    compare_all();
    tick();
    tick();
    reset = 1'b0;

    // 5 retiring instructions, no reads
    clr = 1; tick(); clr = 0;
    en = 1; tick();
    for (int k = 0; k < 5; k++) begin
      pc = 32'(4 * k);
      tick();
    end
    en = 0; pc = '0; tick();
    chk("s1_count", 64'(cnt_a), 64'd5);
    rd_ready = 1;
    for (int k = 0; k < 5; k++) begin
      chk("s1_cyc", 64'(rd_a[166:135]), 64'(k));
      chk("s1_pc", 64'(rd_a[134:103]), 64'(4 * k));
      tick();
    end
    rd_ready = 0;
    chk("s1_empty", 64'(rv_a), 64'd0);

    // MODE=1: write to $zero ignored, write to x16 recorded
    clr = 1; tick(); clr = 0;
    en = 1; tick();
    reg_we = 1; reg_waddr = 5'd0; reg_wdata = 32'h7; tick();
    reg_waddr = 5'd16; reg_wdata = 32'h5; tick();
    reg_we = 0; reg_waddr = '0; reg_wdata = '0; en = 0; tick();
    chk("s2_count", 64'(cnt_b), 64'd1);
    chk("s2_rflag", 64'(rd_b[102]), 64'd1);
    chk("s2_mflag", 64'(rd_b[101]), 64'd0);
    chk("s2_waddr", 64'(rd_b[100:96]), 64'd16);
    chk("s2_wdata", 64'(rd_b[95:64]), 64'd5);
    chk("s2_cyc", 64'(rd_b[166:135]), 64'd1);

    // DEPTH=4 drop mode, 6 events
    clr = 1; tick(); clr = 0;
    en = 1; tick();
    mem_we = 1;
    for (int k = 0; k < 6; k++) begin
      mem_addr = 32'h100 + 32'(k);
      tick();
    end
    mem_we = 0; mem_addr = '0; en = 0; tick();
    chk("s3_count", 64'(cnt_b), 64'd4);
    chk("s3_overflow", 64'(ovf_b), 64'd1);
    chk("s3_drops", 64'(drops_b), 64'd2);
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("s3_addr", 64'(rd_b[63:32]), 64'h100 + 64'(k));
      tick();
    end
    rd_ready = 0;

    // full FIFO, push and pop on the same edge
    clr = 1; tick(); clr = 0;
    en = 1; tick();
    mem_we = 1;
    for (int k = 0; k < 4; k++) begin
      mem_addr = 32'h300 + 32'(k);
      tick();
    end
    chk("s5_full", 64'(cnt_b), 64'd4);
    mem_addr = 32'h3AA; rd_ready = 1; tick();
    mem_we = 0; mem_addr = '0; rd_ready = 0; en = 0; tick();
    chk("s5_count", 64'(cnt_b), 64'd4);
    chk("s5_overflow", 64'(ovf_b), 64'd0);
    exp5[0] = 32'h301; exp5[1] = 32'h302; exp5[2] = 32'h303; exp5[3] = 32'h3AA;
    rd_ready = 1;
    for (int k = 0; k < 4; k++) begin
      chk("s5_addr", 64'(rd_b[63:32]), 64'(exp5[k]));
      tick();
    end
    rd_ready = 0;

    // STOP_ON_FULL=1 freeze
    clr = 1; tick(); clr = 0;
    en = 1; tick();
    for (int k = 0; k < 4; k++) begin
      pc = 32'h40 + 32'(4 * k);
      tick();
    end
    chk("s4_frozen", 64'(frz_c), 64'd1);
    chk("s4_count", 64'(cnt_c), 64'd4);
    chk("s4_cycle", 64'(cyc_c), 64'd4);
    tick(); tick();
    chk("s4_cycle_hold", 64'(cyc_c), 64'd4);
    rd_ready = 1; tick(); rd_ready = 0;
    tick(); tick();
    chk("s4_pop_count", 64'(cnt_c), 64'd3);
    chk("s4_still_frozen", 64'(frz_c), 64'd1);
    clr = 1; tick(); clr = 0;
    chk("s4_clr_frozen", 64'(frz_c), 64'd0);
    chk("s4_clr_count", 64'(cnt_c), 64'd0);
    tick();
    chk("s4_idle_nocap", 64'(cnt_c), 64'd0);
    en = 0; pc = '0; tick();

    // reset pulse between edges
    clr = 1; tick(); clr = 0;
    en = 1; pc = 32'h80;
    repeat (4) tick();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("s6_count", 64'(cnt_a), 64'd0);
    chk("s6_valid", 64'(rv_a), 64'd0);
    chk("s6_cycle", 64'(cyc_a), 64'd0);
    chk_rec("s6_data", rd_a, '0);
    compare_all();
    #1 reset = 1'b0;
    tick(); tick();
    chk("s6_resume_count", 64'(cnt_a), 64'd1);
    chk("s6_resume_cyc", 64'(rd_a[166:135]), 64'd0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      en        = ($urandom % 8) != 0;
      clr       = ($urandom % 97) == 0;
      rd_ready  = ($urandom % 3) == 0;
      pc        = $urandom;
      reg_we    = $urandom_range(0, 1) == 1;
      reg_waddr = (($urandom % 4) == 0) ? 5'd0 : 5'($urandom);
      reg_wdata = $urandom;
      mem_we    = ($urandom % 4) == 0;
      mem_addr  = $urandom;
      mem_wdata = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
